// File: rtl/lane_gather_8.sv
// Gathers one signed W1-bit term per cycle into an 8-lane word, double-buffered (assembly + output).
// Optional zero-padded flush of a partial word: define LANE_GATHER_FLUSH_EN.
module lane_gather_8 #(
    parameter int unsigned W1 = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W1-1:0]     s_data,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [8*W1-1:0]   m_data,
    output logic [3:0]        m_lanes
);

    logic [7:0][W1-1:0] r_asm;
    logic [7:0][W1-1:0] r_out;
    logic [7:0][W1-1:0] w_asm_next;
    logic [3:0]         r_asm_cnt;
    logic               r_asm_full;
    logic               r_m_valid;
    logic [3:0]         r_m_lanes;

    logic               w_in_xfer;
    logic [3:0]         w_cnt_after;
    logic               w_flush_now;
    logic               w_word_done;
    logic               w_move;

    assign s_ready     = !r_asm_full;
    assign w_in_xfer   = s_valid && s_ready;
    assign w_cnt_after = r_asm_cnt + {3'b000, w_in_xfer};

`ifdef LANE_GATHER_FLUSH_EN
    assign w_flush_now = flush && !r_asm_full && (w_cnt_after != 4'd0) && (w_cnt_after < 4'd8);
`else
    assign w_flush_now = flush & 1'b0;
`endif

    // Lanes above the fill count are already zero (assembly is cleared on every move),
    // so a padded flush needs no explicit masking.
    always_comb begin
        w_asm_next = r_asm;
        if (w_in_xfer) begin
            w_asm_next[r_asm_cnt[2:0]] = s_data;
        end
    end

    assign w_word_done = r_asm_full || (w_cnt_after == 4'd8) || w_flush_now;
    assign w_move      = w_word_done && (!r_m_valid || m_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm      <= '0;
            r_asm_cnt  <= '0;
            r_asm_full <= 1'b0;
        end else if (w_move) begin
            r_asm      <= '0;
            r_asm_cnt  <= '0;
            r_asm_full <= 1'b0;
        end else begin
            r_asm      <= w_asm_next;
            r_asm_cnt  <= w_cnt_after;
            r_asm_full <= w_word_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_m_lanes <= '0;
            r_m_valid <= 1'b0;
        end else if (w_move) begin
            r_out     <= w_asm_next;
            r_m_lanes <= w_cnt_after;
            r_m_valid <= 1'b1;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_out;
    assign m_lanes = r_m_lanes;

endmodule
